// File: rtl/slap_delay_line.sv
// slap_delay_line: a DEPTH-stage shift line with a selectable tap (0..DEPTH).
// Data words travel with a valid bit. The line advances on en, and flush
// clears it synchronously. sel=0 bypasses the line with no latency. sel values
// above DEPTH are clamped to DEPTH.
// Optional feature, enabled by macro SLAP_EDGE_DET_EN: per-bit rise/fall
// strobes on dout, qualified by dout_valid.
//
// Valid semantics (there is no ready and no backpressure): din is meaningful
// only when din_valid=1, and dout only when dout_valid=1. dout carries stage
// data even when its valid bit is 0. Words that shift past the last stage are
// dropped.
module slap_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [SW-1:0]    sel,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout
`ifdef SLAP_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam logic [SW-1:0] SEL_MAX = SW'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [SW-1:0]    sel_eff;
  logic [WIDTH-1:0] tap_data;
  logic             tap_valid;

  // Next state of the line: flush wins, otherwise shift by one stage on en.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) data_d[k] = '0;
      valid_d = '0;
    end else if (en) begin
      data_d[0]  = din;
      valid_d[0] = din_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Output tap mux. sel is clamped to DEPTH, and 0 selects the input directly.
  // dout_valid is also gated by rst_n so that it drops immediately during reset,
  // even on the bypass path.
  always_comb begin
    sel_eff   = (sel > SEL_MAX) ? SEL_MAX : sel;
    tap_data  = din;
    tap_valid = din_valid;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel_eff == SW'(k + 1)) begin
        tap_data  = data_q[k];
        tap_valid = valid_q[k];
      end
    end
    dout       = tap_data;
    dout_valid = tap_valid & rst_n;
  end

`ifdef SLAP_EDGE_DET_EN
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  // History register: remembers dout as of the last enabled edge.
  always_comb begin
    prev_d = prev_q;
    if (flush)   prev_d = '0;
    else if (en) prev_d = dout;
  end

  // History register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  // Edge strobes compare the current dout with the history, qualified by dout_valid.
  always_comb begin
    rise = dout & ~prev_q & {WIDTH{dout_valid}};
    fall = ~dout & prev_q & {WIDTH{dout_valid}};
  end
`endif

endmodule

// File: tb/tb_slap_delay_line.sv
// tb_slap_delay_line: self-checking bench for slap_delay_line (WIDTH=8, DEPTH=4).
// A reference model of the line predicts each cycle's {dout_valid, dout}.
// The prediction is queued when the stimulus is driven, then popped and
// compared at the falling edge. Directed checks cover the listed scenarios.
module tb_slap_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             flush;
  logic [SW-1:0]    sel;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             dout_valid;
  logic [WIDTH-1:0] dout;
`ifdef SLAP_EDGE_DET_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`endif

  slap_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .sel        (sel),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout)
`ifdef SLAP_EDGE_DET_EN
    ,
    .rise       (rise),
    .fall       (fall)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] m_d[DEPTH];
  logic       m_v[DEPTH];
  logic [7:0] m_prev;

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_d[k] = 8'h00;
      m_v[k] = 1'b0;
    end
    m_prev = 8'h00;
  endtask

  // Driver: apply one cycle of stimulus, predict the output, check it at
  // negedge, advance the model at posedge. Returns #1 after that posedge.
  task automatic step(input logic e, input logic f, input logic dv,
                      input logic [7:0] d, input logic [2:0] s);
    logic [2:0] se;
    logic [8:0] exp_w;
    en = e; flush = f; din_valid = dv; din = d; sel = s;
    se = (s > 3'd4) ? 3'd4 : s;
    if (se == 3'd0) exp_w = {dv, d};
    else            exp_w = {m_v[se - 3'd1], m_d[se - 3'd1]};
    exp_q.push_back(exp_w);
    @(negedge clk);
    check_val("dout", {dout_valid, dout}, exp_q.pop_front());
`ifdef SLAP_EDGE_DET_EN
    check_val("rise", 9'(rise), 9'(exp_w[7:0] & ~m_prev & {8{exp_w[8]}}));
    check_val("fall", 9'(fall), 9'(~exp_w[7:0] & m_prev & {8{exp_w[8]}}));
`endif
    @(posedge clk);
    if (f) begin
      model_clear();
    end else if (e) begin
      m_prev = exp_w[7:0];
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_d[k] = m_d[k-1];
        m_v[k] = m_v[k-1];
      end
      m_d[0] = d;
      m_v[0] = dv;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; sel = 3'd1; din_valid = 1'b0; din = 8'h00;
    model_clear();
    #3;
    check_val("reset_v", 9'(dout_valid), 9'h000);
    check_val("reset_d", 9'(dout), 9'h000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // sel=2 latency: 0x01,0x02,0x03 appear two edges later
    step(1, 0, 1, 8'h01, 3'd2);
    step(1, 0, 1, 8'h02, 3'd2);
    check_val("lat2_a", {dout_valid, dout}, 9'h101);
    step(1, 0, 1, 8'h03, 3'd2);
    check_val("lat2_b", {dout_valid, dout}, 9'h102);
    step(1, 0, 0, 8'h00, 3'd2);
    check_val("lat2_c", {dout_valid, dout}, 9'h103);
    step(1, 0, 0, 8'h00, 3'd2);

    // sel=0 bypass, no edge needed
    en = 1'b0; sel = 3'd0; din = 8'hA5; din_valid = 1'b1;
    #1;
    check_val("bypass", {dout_valid, dout}, 9'h1A5);
    step(1, 0, 1, 8'hA5, 3'd0);

    // clear the line, then send one 0x3C pulse with sel=4 and en toggling
    step(1, 1, 0, 8'h00, 3'd4);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, 0, i == 0, (i == 0) ? 8'h3C : 8'h00, 3'd4);
    check_val("pulse_early", 9'(dout_valid), 9'h000);
    step(1, 0, 0, 8'h00, 3'd4);
    check_val("pulse_at4", {dout_valid, dout}, 9'h13C);
    for (int i = 7; i < 12; i++) step(i % 2 == 0, 0, 0, 8'h00, 3'd4);

    // random traffic
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));

    // fill with valid data, flush with en=1 and valid din present
    for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 8'(8'h50 + i), 3'd4);
    step(1, 1, 1, 8'hEE, 3'd1);
    en = 1'b0; din_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check_val("flush_v", 9'(dout_valid), 9'h000);
    end
    sel = 3'd1;
    #0.5;
    check_val("flush_d", 9'(dout), 9'h000);
    @(posedge clk); #1;
    for (int s = 0; s < 8; s++) step(0, 0, 0, 8'h00, 3'(s));

    // sel=7 clamps to 4
    step(1, 0, 1, 8'h11, 3'd7);
    step(1, 0, 1, 8'h22, 3'd4);
    step(1, 0, 1, 8'h33, 3'd7);
    step(1, 0, 1, 8'h44, 3'd4);
    en = 1'b0; sel = 3'd7;
    #1 check_val("clamp7", {dout_valid, dout}, 9'h111);
    sel = 3'd4;
    #1 check_val("clamp4", {dout_valid, dout}, 9'h111);
    sel = 3'd2;
    #1 check_val("tap2", {dout_valid, dout}, 9'h133);

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check_val("async_v", 9'(dout_valid), 9'h000);
    check_val("async_d", 9'(dout), 9'h000);
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 0, 0, 8'h00, 3'd2);
    step(1, 0, 1, 8'h5A, 3'd2);
    step(1, 0, 0, 8'h00, 3'd2);
    check_val("resume", {dout_valid, dout}, 9'h15A);
    step(1, 0, 0, 8'h00, 3'd2);
    step(1, 0, 0, 8'h00, 3'd2);

`ifdef SLAP_EDGE_DET_EN
    step(1, 1, 0, 8'h00, 3'd1);
    step(1, 0, 1, 8'h00, 3'd1);
    step(1, 0, 1, 8'h81, 3'd1);
    check_val("edge_rise", 9'(rise), 9'h081);
    check_val("edge_nofall", 9'(fall), 9'h000);
    step(1, 0, 1, 8'h01, 3'd1);
    check_val("edge_fall", 9'(fall), 9'h080);
    check_val("edge_norise", 9'(rise), 9'h000);
    step(1, 0, 0, 8'h00, 3'd1);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
